// File: rtl/uart_apb_rx_fifo.sv
// UART receive FIFO with a zero-wait-state APB register interface.
// Optional level-threshold interrupt is compiled in with UART_APB_RX_FIFO_IRQ_EN.
module uart_apb_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [15:0]       paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              full,
  output logic              empty,
  output logic              irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [LVL_W-1:0] LVL_ONE = 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg, level_next;
  logic              ovf_reg;
  logic              irq_pend_reg;
  logic [7:0]        thresh_reg;
  logic              irq_ie_reg;

  logic       access, addr_ok;
  logic [1:0] reg_sel;
  logic       pop, push, flush, ovf_set, status_wr, ctrl_wr;
  logic       rd_data, rd_status, rd_ctrl, rd_level;
  logic       unused_bits;

  assign access  = psel & penable;
  assign pready  = access;
  assign addr_ok = (paddr[15:4] == 12'h000) && (paddr[1:0] == 2'b00);
  assign reg_sel = paddr[3:2];

  assign full  = (level_reg == LVL_W'(DEPTH));
  assign empty = (level_reg == '0);

  assign rd_data   = access & ~pwrite & addr_ok & (reg_sel == 2'd0);
  assign rd_status = access & ~pwrite & addr_ok & (reg_sel == 2'd1);
  assign rd_ctrl   = access & ~pwrite & addr_ok & (reg_sel == 2'd2);
  assign rd_level  = access & ~pwrite & addr_ok & (reg_sel == 2'd3);
  assign status_wr = access &  pwrite & addr_ok & (reg_sel == 2'd1);
  assign ctrl_wr   = access &  pwrite & addr_ok & (reg_sel == 2'd2);

  assign pop     = rd_data & ~empty;
  assign flush   = ctrl_wr & pwdata[0];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push    = rx_valid & (~full | pop) & ~flush;
  assign ovf_set = rx_valid & full & ~pop & ~flush;

  assign unused_bits = ^pwdata;

  always_comb begin
    level_next = level_reg;
    if (flush)
      level_next = '0;
    else if (push && !pop)
      level_next = level_reg + LVL_ONE;
    else if (pop && !push)
      level_next = level_reg - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      level_reg <= level_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (ovf_set)
        ovf_reg <= 1'b1;
      else if (status_wr && pwdata[2])
        ovf_reg <= 1'b0;
    end
  end

`ifdef UART_APB_RX_FIFO_IRQ_EN
  logic irq_set;
  // Fire only on the upward crossing of the threshold, not while merely above it.
  assign irq_set = (thresh_reg != 8'd0) && !rst
                && (32'(level_reg) < 32'(thresh_reg))
                && (32'(level_next) >= 32'(thresh_reg));

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_pend_reg <= 1'b0;
      thresh_reg   <= 8'd0;
      irq_ie_reg   <= 1'b0;
    end else begin
      if (irq_set)
        irq_pend_reg <= 1'b1;
      else if (status_wr && pwdata[3])
        irq_pend_reg <= 1'b0;
      if (ctrl_wr) begin
        thresh_reg <= pwdata[15:8];
        irq_ie_reg <= pwdata[1];
      end
    end
  end
`else
  assign irq_pend_reg = 1'b0;
  assign thresh_reg   = 8'd0;
  assign irq_ie_reg   = 1'b0;
`endif

  assign irq = irq_pend_reg & irq_ie_reg;

  always_comb begin
    prdata  = 32'd0;
    pslverr = 1'b0;
    if (access && !rst) begin
      if (!addr_ok)
        pslverr = 1'b1;
      else if (pwrite)
        pslverr = (reg_sel == 2'd0) || (reg_sel == 2'd3);
      else if (rd_data) begin
        if (empty) pslverr = 1'b1;
        else       prdata[DATA_W-1:0] = mem[rd_ptr_reg];
      end else if (rd_status)
        prdata[3:0] = {irq_pend_reg, ovf_reg, full, empty};
      else if (rd_ctrl)
        prdata[15:0] = {thresh_reg, 6'd0, irq_ie_reg, 1'b0};
      else if (rd_level)
        prdata[LVL_W-1:0] = level_reg;
    end
  end

endmodule
